// File: rtl/controlador_soma_matrizes_pkg.sv
// Shared coprocessor definitions: default geometry, controller state encoding
// and the element-index helper used to flatten a DIM x DIM matrix.
package controlador_soma_matrizes_pkg;

  localparam int DIM_PADRAO      = 5;
  localparam int LARGURA_PADRAO  = 8;
  localparam int NE_PADRAO       = DIM_PADRAO * DIM_PADRAO;
  localparam int MATRIZ_5X5_MSB  = NE_PADRAO * LARGURA_PADRAO - 1;
  localparam int MATRIZ_5X5_LSB  = 0;

  typedef enum logic [2:0] {
    OCIOSO,
    CARGA_A,
    CARGA_B,
    CALCULA,
    ENVIA
  } estado_t;

  // Column-major flattening: element (linha, coluna) sits at slot linha + dim*coluna.
  function automatic int indice(input int linha, input int coluna, input int dim);
    return linha + dim * coluna;
  endfunction

endpackage

// File: rtl/somador_matrizes.sv
// Purely combinational element-wise adder of two flattened DIM x DIM matrices;
// each lane wraps modulo 2^LARGURA.
module somador_matrizes
  import controlador_soma_matrizes_pkg::*;
#(
  parameter int DIM     = DIM_PADRAO,
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [DIM*DIM*LARGURA-1:0] a,
  input  logic [DIM*DIM*LARGURA-1:0] b,
  output logic [DIM*DIM*LARGURA-1:0] soma
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_linha
      for (gj = 0; gj < DIM; gj++) begin : g_coluna
        localparam int K = indice(gi, gj, DIM);
        assign soma[LARGURA*K +: LARGURA] = a[LARGURA*K +: LARGURA] + b[LARGURA*K +: LARGURA];
      end
    end
  endgenerate

endmodule

// File: rtl/controlador_soma_matrizes.sv
// Streams in matrices A and B element by element, adds them in one cycle and
// streams the result back out with valid/ready handshakes on both sides.
module controlador_soma_matrizes
  import controlador_soma_matrizes_pkg::*;
#(
  parameter int DIM     = DIM_PADRAO,
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] entrada_dado,
  input  logic               entrada_valida,
  output logic               entrada_pronta,
  output logic [LARGURA-1:0] saida_dado,
  output logic               saida_valida,
  input  logic               saida_pronta,
  output logic               ocupado,
  output logic               concluido
);

  localparam int NE = DIM * DIM;
  localparam int CW = $clog2(NE);
  localparam logic [CW-1:0] ULTIMO = CW'(NE - 1);

  estado_t               estado;
  logic [CW-1:0]         contador;
  logic [NE*LARGURA-1:0] mat_a;
  logic [NE*LARGURA-1:0] mat_b;
  logic [NE*LARGURA-1:0] resultado;
  logic [NE*LARGURA-1:0] soma;
  logic                  transfere;
  logic                  aceita;

  somador_matrizes #(
    .DIM     (DIM),
    .LARGURA (LARGURA)
  ) u_somador (
    .a    (mat_a),
    .b    (mat_b),
    .soma (soma)
  );

  assign transfere = entrada_valida && entrada_pronta;
  assign aceita    = saida_valida && saida_pronta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= OCIOSO;
      contador       <= '0;
      mat_a          <= '0;
      mat_b          <= '0;
      resultado      <= '0;
      entrada_pronta <= 1'b0;
      saida_valida   <= 1'b0;
      saida_dado     <= '0;
      ocupado        <= 1'b0;
      concluido      <= 1'b0;
    end else begin
      concluido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado         <= CARGA_A;
            contador       <= '0;
            entrada_pronta <= 1'b1;
            ocupado        <= 1'b1;
          end
        end
        CARGA_A: begin
          if (transfere) begin
            mat_a[LARGURA*int'(contador) +: LARGURA] <= entrada_dado;
            if (contador == ULTIMO) begin
              estado   <= CARGA_B;
              contador <= '0;
            end else begin
              contador <= contador + 1'b1;
            end
          end
        end
        CARGA_B: begin
          if (transfere) begin
            mat_b[LARGURA*int'(contador) +: LARGURA] <= entrada_dado;
            if (contador == ULTIMO) begin
              estado         <= CALCULA;
              contador       <= '0;
              entrada_pronta <= 1'b0;
            end else begin
              contador <= contador + 1'b1;
            end
          end
        end
        CALCULA: begin
          // Element 0 is taken straight from the adder so it is ready in the first ENVIA cycle.
          resultado    <= soma;
          saida_dado   <= soma[LARGURA-1:0];
          saida_valida <= 1'b1;
          contador     <= '0;
          estado       <= ENVIA;
        end
        ENVIA: begin
          if (aceita) begin
            if (contador == ULTIMO) begin
              estado       <= OCIOSO;
              contador     <= '0;
              saida_valida <= 1'b0;
              ocupado      <= 1'b0;
              concluido    <= 1'b1;
            end else begin
              contador   <= contador + 1'b1;
              saida_dado <= resultado[LARGURA*(int'(contador) + 1) +: LARGURA];
            end
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_soma_matrizes.sv
// Directed and randomized bench for the matrix-addition controller; results are
// compared against a plain modular-arithmetic reference kept in the bench.
module tb_controlador_soma_matrizes;

  localparam int NE       = 25;
  localparam int LATENCIA = 77;
  localparam int GUARDA   = 1000;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] entrada_dado;
  logic       entrada_valida;
  logic       entrada_pronta;
  logic [7:0] saida_dado;
  logic       saida_valida;
  logic       saida_pronta;
  logic       ocupado;
  logic       concluido;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_concl  = 0;
  int n_ops    = 0;

  logic [7:0] a_ref [NE];
  logic [7:0] b_ref [NE];

  controlador_soma_matrizes dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .entrada_dado   (entrada_dado),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saida_dado     (saida_dado),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .ocupado        (ocupado),
    .concluido      (concluido)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (concluido === 1'b1) n_concl <= n_concl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic dados_aleatorios();
    for (int i = 0; i < NE; i++) begin
      a_ref[i] = 8'($urandom);
      b_ref[i] = 8'($urandom);
    end
  endtask

  // modo 0: no stalls, latency checked; modo 1: random entrada_valida, toggling saida_pronta.
  task automatic operacao(input int modo, input bit iniciar_extra);
    logic [7:0] esperado [NE];
    int idx;
    int k;
    int guarda;
    int inicio;
    for (int i = 0; i < NE; i++) esperado[i] = 8'(a_ref[i] + b_ref[i]);

    inicio  = cyc;
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    n_ops++;
    chk("pronta_apos_iniciar", entrada_pronta, 1);
    chk("ocupado_apos_iniciar", ocupado, 1);
    chk("concluido_baixo_inicio", concluido, 0);

    idx = 0;
    guarda = 0;
    while (idx < 2*NE && guarda < GUARDA) begin
      entrada_valida = (modo == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (entrada_valida) entrada_dado = (idx < NE) ? a_ref[idx] : b_ref[idx-NE];
      else                entrada_dado = 8'($urandom);
      if (iniciar_extra && idx == 5) iniciar = 1'b1;
      chk($sformatf("entrada_pronta[%0d]", idx), entrada_pronta, 1);
      ciclo();
      iniciar = 1'b0;
      if (entrada_valida) idx++;
      guarda++;
    end
    entrada_valida = 1'b0;
    chk("carga_completa", idx, 2*NE);

    chk("calcula_pronta", entrada_pronta, 0);
    chk("calcula_saida_valida", saida_valida, 0);
    chk("calcula_ocupado", ocupado, 1);
    ciclo();

    k = 0;
    guarda = 0;
    while (k < NE && guarda < GUARDA) begin
      saida_pronta = (modo == 0) ? 1'b1 : 1'(guarda % 2);
      if (iniciar_extra && k == 12) iniciar = 1'b1;
      chk("saida_valida", saida_valida, 1);
      chk($sformatf("saida_dado[%0d]", k), saida_dado, esperado[k]);
      ciclo();
      iniciar = 1'b0;
      if (saida_pronta) k++;
      guarda++;
    end
    saida_pronta = 1'b0;
    chk("envio_completo", k, NE);
    chk("concluido_pulso", concluido, 1);
    chk("saida_valida_fim", saida_valida, 0);
    chk("ocupado_fim", ocupado, 0);
    if (modo == 0) chk("latencia", cyc - inicio, LATENCIA);
  endtask

  initial begin
    reset          = 1'b1;
    iniciar        = 1'b0;
    entrada_dado   = '0;
    entrada_valida = 1'b0;
    saida_pronta   = 1'b0;
    ciclo();
    ciclo();
    chk("reset_pronta", entrada_pronta, 0);
    chk("reset_saida_valida", saida_valida, 0);
    chk("reset_saida_dado", saida_dado, 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_concluido", concluido, 0);
    reset = 1'b0;

    // Basic pattern, then a back-to-back random operation.
    for (int i = 0; i < NE; i++) begin
      a_ref[i] = 8'(i);
      b_ref[i] = 8'(2*i);
    end
    operacao(0, 1'b0);
    $display("op basico: n_fail=%0d", n_fail);
    dados_aleatorios();
    operacao(0, 1'b0);
    $display("op back-to-back: n_fail=%0d", n_fail);
    ciclo();

    // Wrap-around cases.
    for (int i = 0; i < NE; i++) begin
      a_ref[i] = 8'h7F;
      b_ref[i] = 8'h01;
    end
    operacao(0, 1'b0);
    $display("op wrap 127+1: n_fail=%0d", n_fail);
    ciclo();
    for (int i = 0; i < NE; i++) begin
      a_ref[i] = 8'h80;
      b_ref[i] = 8'hFF;
    end
    operacao(0, 1'b0);
    $display("op wrap -128-1: n_fail=%0d", n_fail);
    ciclo();

    // Backpressure on both sides with the basic pattern.
    for (int i = 0; i < NE; i++) begin
      a_ref[i] = 8'(i);
      b_ref[i] = 8'(2*i);
    end
    operacao(1, 1'b0);
    $display("op backpressure: n_fail=%0d", n_fail);
    ciclo();

    // Spurious iniciar while busy.
    dados_aleatorios();
    operacao(0, 1'b1);
    $display("op iniciar ignorado: n_fail=%0d", n_fail);
    dados_aleatorios();
    operacao(1, 1'b1);
    $display("op iniciar ignorado com stalls: n_fail=%0d", n_fail);
    ciclo();

    // Reset in the middle of loading B.
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    entrada_valida = 1'b1;
    for (int i = 0; i < NE + 10; i++) begin
      entrada_dado = 8'($urandom);
      ciclo();
    end
    chk("pre_reset_pronta", entrada_pronta, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async_pronta", entrada_pronta, 0);
    chk("reset_async_saida_valida", saida_valida, 0);
    chk("reset_async_saida_dado", saida_dado, 0);
    chk("reset_async_ocupado", ocupado, 0);
    chk("reset_async_concluido", concluido, 0);
    entrada_valida = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    dados_aleatorios();
    operacao(1, 1'b0);
    $display("op apos reset: n_fail=%0d", n_fail);
    ciclo();

    chk("contagem_concluido", n_concl, n_ops);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
